// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_arbiter_pkg : shared constants for the two-port cache arbiter      |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package cache_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t WAIT_W = 2'd2;
  localparam state_t WAIT_R = 2'd3;

  localparam logic PORT_LOADER = 1'b0;
  localparam logic PORT_CPU    = 1'b1;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  function automatic logic is_read(input logic [3:0] wstrb);
    return wstrb == WSTRB_READ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_arbiter_picker : combinational winner select between two ports     |
// | Round-robin tie-break when CACHE_ARBITER_ROUND_ROBIN_EN is defined.      |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module cache_arbiter_picker
  import cache_arbiter_pkg::*;
(
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  input  logic rr_ptr,
`endif
  input  logic req0,
  input  logic req1,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req0 | req1;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant = rr_ptr;
    end else begin
      grant = req0 ? PORT_LOADER : PORT_CPU;
    end
`else
    grant = req0 ? PORT_LOADER : PORT_CPU;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_arbiter : shares one cache port between the flash loader (port 0)  |
// | and the CPU/UART side (port 1) with req/ack handshakes and a timeout.    |
// | Optional macro: CACHE_ARBITER_ROUND_ROBIN_EN (round-robin tie-break).    |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_BITWIDTH    = 32,
  parameter int TIMEOUT_BITWIDTH = 16
) (
  input  logic                     br_clk_out,
  input  logic                     sys_rst_n,
  input  logic                     cache_ready,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [ADDR_BITWIDTH-1:0] addr0,
  input  logic [ADDR_BITWIDTH-1:0] addr1,
  input  logic [31:0]              wdata0,
  input  logic [31:0]              wdata1,
  input  logic [3:0]               wstrb0,
  input  logic [3:0]               wstrb1,
  output logic                     ack0,
  output logic                     ack1,
  output logic                     err0,
  output logic                     err1,
  output logic [31:0]              rdata,
  output logic [ADDR_BITWIDTH-1:0] cache_address,
  output logic [31:0]              cache_data_in,
  output logic [3:0]               cache_write_enable,
  input  logic [31:0]              cache_data_out,
  input  logic                     cache_data_out_ready,
  input  logic                     cache_busy
);

  localparam logic [TIMEOUT_BITWIDTH-1:0] c_CNT_MAX = {TIMEOUT_BITWIDTH{1'b1}};

  state_t                      r_state;
  logic                        r_grant;
  logic [TIMEOUT_BITWIDTH-1:0] r_cnt;
  logic [TIMEOUT_BITWIDTH-1:0] w_cnt_next;
  logic                        w_waiting;
  logic                        w_done;
  logic                        w_timeout;
  logic                        w_finish;
  logic                        w_fail;
  logic                        w_pick_valid;
  logic                        w_pick;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  logic r_rr;
`endif

  cache_arbiter_picker u_picker (
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    .rr_ptr (r_rr),
`endif
    .req0   (req0),
    .req1   (req1),
    .valid  (w_pick_valid),
    .grant  (w_pick)
  );

  // Counter saturates; the timeout fires on the cycle it reaches all-ones.
  always_comb begin
    w_cnt_next = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_waiting  = (r_state == WAIT_W) || (r_state == WAIT_R);
    w_done     = ((r_state == WAIT_W) && !cache_busy) ||
                 ((r_state == WAIT_R) && cache_data_out_ready);
    w_timeout  = w_waiting && (w_cnt_next == c_CNT_MAX);
    w_finish   = w_done || w_timeout;
    w_fail     = !w_done && w_timeout;
  end

  always_ff @(posedge br_clk_out or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state            <= IDLE;
      r_grant            <= PORT_LOADER;
      r_cnt              <= '0;
      ack0               <= 1'b0;
      ack1               <= 1'b0;
      err0               <= 1'b0;
      err1               <= 1'b0;
      rdata              <= '0;
      cache_address      <= '0;
      cache_data_in      <= '0;
      cache_write_enable <= WSTRB_READ;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      r_rr               <= PORT_LOADER;
`endif
    end else if (!cache_ready) begin
      // Abort without ack; a still-held req is reissued once the cache is back.
      r_state            <= IDLE;
      r_grant            <= PORT_LOADER;
      r_cnt              <= '0;
      ack0               <= 1'b0;
      ack1               <= 1'b0;
      err0               <= 1'b0;
      err1               <= 1'b0;
      rdata              <= '0;
      cache_address      <= '0;
      cache_data_in      <= '0;
      cache_write_enable <= WSTRB_READ;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      r_rr               <= PORT_LOADER;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!cache_busy && w_pick_valid) begin
            r_grant            <= w_pick;
            r_cnt              <= '0;
            cache_address      <= (w_pick == PORT_CPU) ? addr1  : addr0;
            cache_data_in      <= (w_pick == PORT_CPU) ? wdata1 : wdata0;
            cache_write_enable <= (w_pick == PORT_CPU) ? wstrb1 : wstrb0;
            r_state            <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= is_read(cache_write_enable) ? WAIT_R : WAIT_W;
        end
        WAIT_W, WAIT_R: begin
          r_cnt <= w_cnt_next;
          if (w_finish) begin
            ack0               <= (r_grant == PORT_LOADER);
            ack1               <= (r_grant == PORT_CPU);
            err0               <= w_fail && (r_grant == PORT_LOADER);
            err1               <= w_fail && (r_grant == PORT_CPU);
            cache_write_enable <= WSTRB_READ;
            r_state            <= IDLE;
            if (w_done && (r_state == WAIT_R)) begin
              rdata <= cache_data_out;
            end
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
            r_rr <= ~r_rr;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
